// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: ALU command codes, shifter
// type codes and the bit positions of the NZCV flags in the status register.
package arm_pkg;

   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_MVN = 4'b1001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;

   localparam logic [1:0] SHIFT_LSL = 2'b00;
   localparam logic [1:0] SHIFT_LSR = 2'b01;
   localparam logic [1:0] SHIFT_ASR = 2'b10;
   localparam logic [1:0] SHIFT_ROR = 2'b11;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Second-operand generator: memory offset, rotated 8-bit immediate, or
// shifted register, in that priority order. Purely combinational.
module val2_gen
   import arm_pkg::*;
(
   input  logic [31:0] val_rm,
   input  logic [11:0] shift_operand,
   input  logic        imm,
   input  logic        mem_access,
   output logic [31:0] val2
);

   logic [31:0] immBase;
   logic [4:0]  immRot;
   logic [4:0]  shiftAmt;
   logic [1:0]  shiftType;
   logic        unusedRegShiftBit;

   assign immBase           = {24'b0, shift_operand[7:0]};
   assign immRot            = {shift_operand[11:8], 1'b0};
   assign shiftAmt          = shift_operand[11:7];
   assign shiftType         = shift_operand[6:5];
   assign unusedRegShiftBit = shift_operand[4];

   // Select and shape the second ALU operand
   always_comb begin
      val2 = val_rm;
      if (mem_access) begin
         val2 = {20'b0, shift_operand};
      end else if (imm) begin
         if (immRot == 5'd0)
            val2 = immBase;
         else
            val2 = (immBase >> immRot) | (immBase << (6'd32 - {1'b0, immRot}));
      end else if (shiftAmt != 5'd0) begin
         case (shiftType)
            SHIFT_LSL: val2 = val_rm << shiftAmt;
            SHIFT_LSR: val2 = val_rm >> shiftAmt;
            SHIFT_ASR: val2 = $unsigned($signed(val_rm) >>> shiftAmt);
            default:   val2 = (val_rm >> shiftAmt) | (val_rm << (6'd32 - {1'b0, shiftAmt}));
         endcase
      end
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: builds Val2, runs the ALU, keeps the NZCV flags, resolves the
// branch target and registers results into the EXE/MEM pipeline register.
module exe_stage
   import arm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             s_in,
   input  logic             branch_in,
   input  logic             mem_r_in,
   input  logic             mem_w_in,
   input  logic             wb_en_in,
   input  logic [3:0]       exe_cmd,
   input  logic [WIDTH-1:0] val_rn,
   input  logic [WIDTH-1:0] val_rm,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [23:0]      imm24,
   input  logic [3:0]       rd_in,
   input  logic             imm,
   input  logic [11:0]      shift_operand,
   output logic [3:0]       status_reg,
   output logic             branch_taken,
   output logic [WIDTH-1:0] branch_addr,
   output logic             wb_en_out,
   output logic             mem_r_out,
   output logic             mem_w_out,
   output logic [WIDTH-1:0] alu_res,
   output logic [WIDTH-1:0] val_rm_out,
   output logic [3:0]       rd_out
);

   logic [31:0] val2;
   logic [31:0] aluValue;
   logic [32:0] sum33;
   logic        carryIn;
   logic        newC;
   logic        newV;
   logic        cmdValid;

   val2_gen uVal2Gen (
      .val_rm        (val_rm),
      .shift_operand (shift_operand),
      .imm           (imm),
      .mem_access    (mem_r_in | mem_w_in),
      .val2          (val2)
   );

   assign carryIn      = status_reg[FLAG_C];
   assign branch_taken = branch_in;
   assign branch_addr  = pc_in + {{6{imm24[23]}}, imm24, 2'b00};

   // ALU: result plus the carry/overflow the command would produce
   always_comb begin
      sum33    = '0;
      aluValue = '0;
      newC     = carryIn;
      newV     = status_reg[FLAG_V];
      cmdValid = 1'b1;
      case (exe_cmd)
         EXE_MOV: aluValue = val2;
         EXE_MVN: aluValue = ~val2;
         EXE_ADD, EXE_ADC: begin
            sum33    = {1'b0, val_rn} + {1'b0, val2} + {32'b0, (exe_cmd == EXE_ADC) & carryIn};
            aluValue = sum33[31:0];
            newC     = sum33[32];
            newV     = (val_rn[31] == val2[31]) && (aluValue[31] != val_rn[31]);
         end
         EXE_SUB, EXE_SBC: begin
            sum33    = {1'b0, val_rn} + {1'b0, ~val2} + {32'b0, (exe_cmd == EXE_SUB) | carryIn};
            aluValue = sum33[31:0];
            newC     = sum33[32];
            newV     = (val_rn[31] != val2[31]) && (aluValue[31] != val_rn[31]);
         end
         EXE_AND: aluValue = val_rn & val2;
         EXE_ORR: aluValue = val_rn | val2;
         EXE_EOR: aluValue = val_rn ^ val2;
         default: cmdValid = 1'b0;
      endcase
   end

   // Status register: updated only by valid, S-flagged, unfrozen instructions
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         status_reg <= 4'b0;
      else if (!freeze && s_in && cmdValid)
         status_reg <= {aluValue[31], aluValue == 32'b0, newC, newV};
   end

   // EXE/MEM pipeline register, held while frozen
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_out  <= 1'b0;
         mem_r_out  <= 1'b0;
         mem_w_out  <= 1'b0;
         alu_res    <= '0;
         val_rm_out <= '0;
         rd_out     <= 4'b0;
      end else if (!freeze) begin
         wb_en_out  <= wb_en_in;
         mem_r_out  <= mem_r_in;
         mem_w_out  <= mem_w_in;
         alu_res    <= aluValue;
         val_rm_out <= val_rm;
         rd_out     <= rd_in;
      end
   end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed and random steps checked against an
// arithmetic reference model of the execute stage.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze, s_in, branch_in, mem_r_in, mem_w_in, wb_en_in, imm;
   logic [3:0]  exe_cmd, rd_in;
   logic [31:0] val_rn, val_rm, pc_in;
   logic [23:0] imm24;
   logic [11:0] shift_operand;
   logic [3:0]  status_reg, rd_out;
   logic        branch_taken, wb_en_out, mem_r_out, mem_w_out;
   logic [31:0] branch_addr, alu_res, val_rm_out;

   int assertCount = 0;
   int failCount   = 0;

   logic [31:0] mAlu, mRm;
   logic [3:0]  mRd, mFlags;
   logic        mWb, mMr, mMw;

   exe_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze), .s_in(s_in), .branch_in(branch_in),
      .mem_r_in(mem_r_in), .mem_w_in(mem_w_in), .wb_en_in(wb_en_in), .exe_cmd(exe_cmd),
      .val_rn(val_rn), .val_rm(val_rm), .pc_in(pc_in), .imm24(imm24), .rd_in(rd_in),
      .imm(imm), .shift_operand(shift_operand), .status_reg(status_reg),
      .branch_taken(branch_taken), .branch_addr(branch_addr), .wb_en_out(wb_en_out),
      .mem_r_out(mem_r_out), .mem_w_out(mem_w_out), .alu_res(alu_res),
      .val_rm_out(val_rm_out), .rd_out(rd_out)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   function automatic logic [31:0] modelVal2(input logic [31:0] rm, input logic [11:0] so,
                                             input logic im, input logic mem);
      logic [63:0] dbl;
      int amt;
      if (mem) return {20'b0, so};
      if (im) begin
         dbl = {24'b0, so[7:0], 24'b0, so[7:0]};
         dbl = dbl >> (2 * int'(so[11:8]));
         return dbl[31:0];
      end
      amt = int'(so[11:7]);
      if (amt == 0) return rm;
      case (so[6:5])
         2'b00: return rm << amt;
         2'b01: return rm >> amt;
         2'b10: return $unsigned($signed(rm) >>> amt);
         default: begin
            dbl = {rm, rm} >> amt;
            return dbl[31:0];
         end
      endcase
   endfunction

   function automatic void modelAlu(input logic [3:0] cmd, input logic [31:0] rn,
                                    input logic [31:0] v2, input logic [3:0] flagsIn,
                                    output logic [31:0] res, output logic [3:0] flagsOut,
                                    output logic valid);
      longint unsigned ua, ub, unb, u;
      longint sa, sb, s, cinL;
      logic [31:0] nv;
      logic c, v, arith;
      nv    = ~v2;
      ua    = longint'(rn);
      ub    = longint'(v2);
      unb   = longint'(nv);
      sa    = longint'($signed(rn));
      sb    = longint'($signed(v2));
      cinL  = flagsIn[1] ? 1 : 0;
      c     = flagsIn[1];
      v     = flagsIn[0];
      valid = 1'b1;
      arith = 1'b0;
      u     = 0;
      s     = 0;
      res   = '0;
      case (cmd)
         4'b0001: res = v2;
         4'b1001: res = ~v2;
         4'b0010: begin u = ua + ub;               s = sa + sb;              arith = 1'b1; end
         4'b0011: begin u = ua + ub + cinL;        s = sa + sb + cinL;       arith = 1'b1; end
         4'b0100: begin u = ua + unb + 1;          s = sa - sb;              arith = 1'b1; end
         4'b0101: begin u = ua + unb + cinL;       s = sa - sb - (1 - cinL); arith = 1'b1; end
         4'b0110: res = rn & v2;
         4'b0111: res = rn | v2;
         4'b1000: res = rn ^ v2;
         default: valid = 1'b0;
      endcase
      if (arith) begin
         res = u[31:0];
         c   = u[32];
         v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      flagsOut = {res[31], res == 32'b0, c, v};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkRegistered();
      checkOutput("alu_res",    alu_res,              mAlu);
      checkOutput("status_reg", {28'b0, status_reg},  {28'b0, mFlags});
      checkOutput("val_rm_out", val_rm_out,           mRm);
      checkOutput("rd_out",     {28'b0, rd_out},      {28'b0, mRd});
      checkOutput("ctrl_out",   {29'b0, wb_en_out, mem_r_out, mem_w_out}, {29'b0, mWb, mMr, mMw});
   endtask

   task automatic modelReset();
      mAlu = '0; mRm = '0; mRd = '0; mFlags = '0; mWb = 0; mMr = 0; mMw = 0;
   endtask

   task automatic applyStimulus(input logic fr, input logic s, input logic br, input logic mr,
                                input logic mw, input logic wb, input logic [3:0] cmd,
                                input logic [31:0] rn, input logic [31:0] rm,
                                input logic [31:0] pc, input logic [23:0] i24,
                                input logic [3:0] rd, input logic im, input logic [11:0] so);
      logic [31:0] v2, res, expAddr;
      logic [3:0]  fl;
      logic        valid;
      freeze = fr; s_in = s; branch_in = br; mem_r_in = mr; mem_w_in = mw; wb_en_in = wb;
      exe_cmd = cmd; val_rn = rn; val_rm = rm; pc_in = pc; imm24 = i24; rd_in = rd;
      imm = im; shift_operand = so;
      #1;
      expAddr = pc + 32'(longint'($signed(i24)) * 4);
      checkOutput("branch_taken", {31'b0, branch_taken}, {31'b0, br});
      checkOutput("branch_addr", branch_addr, expAddr);
      v2 = modelVal2(rm, so, im, mr | mw);
      modelAlu(cmd, rn, v2, mFlags, res, fl, valid);
      @(posedge clk);
      #1;
      if (!fr) begin
         mAlu = res; mRm = rm; mRd = rd; mWb = wb; mMr = mr; mMw = mw;
         if (s && valid) mFlags = fl;
      end
      checkRegistered();
   endtask

   // Directed steps, then random steps, then an asynchronous reset mid-cycle
   initial begin
      rst = 1'b0;
      freeze = 0; s_in = 0; branch_in = 0; mem_r_in = 0; mem_w_in = 0; wb_en_in = 0;
      exe_cmd = 0; val_rn = 0; val_rm = 0; pc_in = 0; imm24 = 0; rd_in = 0; imm = 0;
      shift_operand = 0;
      modelReset();
      #12;
      checkRegistered();
      rst = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(0, 1, 0, 0, 0, 1, 4'b0010, 32'h7FFFFFFF, 32'h0, 32'h0, 24'h0, 4'd1, 1, 12'h001);
      checkOutput("tp_add_res", alu_res, 32'h80000000);
      checkOutput("tp_add_flags", {28'b0, status_reg}, 32'h9);

      applyStimulus(0, 1, 0, 0, 0, 0, 4'b0100, 32'd5, 32'd5, 32'h0, 24'h0, 4'd0, 0, 12'h000);
      checkOutput("tp_sub_res", alu_res, 32'h0);
      checkOutput("tp_sub_flags", {28'b0, status_reg}, 32'h6);

      applyStimulus(0, 1, 0, 0, 0, 1, 4'b0011, 32'd1, 32'd1, 32'h0, 24'h0, 4'd2, 0, 12'h000);
      checkOutput("tp_adc_res", alu_res, 32'd3);

      applyStimulus(0, 0, 0, 0, 0, 1, 4'b0001, 32'h0, 32'h80000001, 32'h0, 24'h0, 4'd3, 0, 12'h0C0);
      checkOutput("tp_asr", alu_res, 32'hC0000000);
      applyStimulus(0, 0, 0, 0, 0, 1, 4'b0001, 32'h0, 32'h80000001, 32'h0, 24'h0, 4'd3, 0, 12'h260);
      checkOutput("tp_ror", alu_res, 32'h18000000);
      applyStimulus(0, 0, 0, 0, 0, 1, 4'b0001, 32'h0, 32'h80000001, 32'h0, 24'h0, 4'd3, 1, 12'h4FF);
      checkOutput("tp_imm_rot", alu_res, 32'hFF000000);

      applyStimulus(0, 0, 0, 1, 0, 1, 4'b0010, 32'h400, 32'h0, 32'h0, 24'h0, 4'd4, 0, 12'hFFC);
      checkOutput("tp_ldr_addr", alu_res, 32'h13FC);
      checkOutput("tp_ldr_memr", {31'b0, mem_r_out}, 32'd1);

      applyStimulus(0, 1, 1, 0, 0, 0, 4'b0100, 32'd1, 32'd2, 32'h100, 24'hFFFFFE, 4'd0, 0, 12'h000);
      checkOutput("tp_branch_addr", branch_addr, 32'hF8);

      applyStimulus(1, 1, 0, 0, 1, 1, 4'b0010, 32'h12345678, 32'h9ABCDEF0, 32'h0, 24'h0, 4'd9, 0, 12'h000);
      checkOutput("tp_freeze_res", alu_res, 32'hFFFFFFFF);

      applyStimulus(0, 1, 0, 0, 0, 1, 4'b1100, 32'h1, 32'h1, 32'h0, 24'h0, 4'd5, 0, 12'h000);
      checkOutput("tp_invalid_res", alu_res, 32'h0);

      for (int i = 0; i < 80; i++) begin
         int memSel;
         memSel = $urandom_range(0, 7);
         applyStimulus(($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
                       memSel == 0, memSel == 1, 1'($urandom), 4'($urandom),
                       $urandom, $urandom, $urandom, 24'($urandom), 4'($urandom),
                       1'($urandom), 12'($urandom));
      end

      applyStimulus(0, 1, 0, 0, 0, 1, 4'b1001, 32'h0, 32'h0, 32'h0, 24'h0, 4'd7, 1, 12'h000);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      modelReset();
      checkRegistered();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 1, 4'b0111, 32'hF0, 32'h0F, 32'h0, 24'h0, 4'd6, 0, 12'h000);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
